// File: rtl/bit_serializer_pkg.sv
// ============================================================================
//  Module      : bit_serializer_pkg
//  Description : Shared state encoding and sizing helper for bit_serializer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bit_serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_GAP    = 2'd3
    } ser_state_t;

    // Width of a counter that must hold values 0..width without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
//  Module      : bit_serializer
//  Description : Valid/ready parallel-to-serial transmitter with frame strobes.
//                Define SER_PARITY_EN to append an even-parity bit per frame.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int               CNT_W      = cnt_width(WIDTH);
    localparam int               GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int               OUT_IDX    = (LSB_FIRST != 0) ? 0 : WIDTH - 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               C_B2B      = (GAP_CYCLES == 0);

    ser_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic             w_last_bit;
    logic             w_accept;
    logic             w_sdo_nxt;
    logic             w_sdo_valid_nxt;
    logic             w_frame_start_nxt;
    logic             w_frame_end_nxt;

`ifdef SER_PARITY_EN
    logic r_parity, w_parity_nxt;

    assign w_last_bit   = (r_state == S_PARITY);
    assign w_parity_nxt = w_accept ? ^in_data : r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_parity <= 1'b0;
        else        r_parity <= w_parity_nxt;
    end
`else
    assign w_last_bit = (r_state == S_SHIFT) && (r_bit_cnt == C_LAST_BIT);
`endif

    // The final bit of a frame doubles as an accept slot when frames run back-to-back.
    assign in_ready = rst_n && ((r_state == S_IDLE) || (C_B2B && w_last_bit));
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            S_IDLE: ;
            S_SHIFT: begin
                if (r_bit_cnt == C_LAST_BIT) begin
`ifdef SER_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt   = C_B2B ? S_IDLE : S_GAP;
                    w_gap_cnt_nxt = '0;
`endif
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (LSB_FIRST != 0) w_shreg_nxt = r_shreg >> 1;
                    else                w_shreg_nxt = r_shreg << 1;
                end
            end
            S_PARITY: begin
                w_state_nxt   = C_B2B ? S_IDLE : S_GAP;
                w_gap_cnt_nxt = '0;
            end
            S_GAP: begin
                if (r_gap_cnt == C_GAP_LAST) w_state_nxt   = S_IDLE;
                else                         w_gap_cnt_nxt = r_gap_cnt + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_accept) begin
            w_state_nxt   = S_SHIFT;
            w_shreg_nxt   = in_data;
            w_bit_cnt_nxt = '0;
        end
    end

    // Outputs are registered by decoding the next state, so they line up with it.
    always_comb begin
        w_sdo_valid_nxt   = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_PARITY);
        w_frame_start_nxt = (w_state_nxt == S_SHIFT) && (w_bit_cnt_nxt == '0);
        w_sdo_nxt         = 1'b0;
        if (w_state_nxt == S_SHIFT) w_sdo_nxt = w_shreg_nxt[OUT_IDX];
`ifdef SER_PARITY_EN
        if (w_state_nxt == S_PARITY) w_sdo_nxt = w_parity_nxt;
        w_frame_end_nxt = (w_state_nxt == S_PARITY);
`else
        w_frame_end_nxt = (w_state_nxt == S_SHIFT) && (w_bit_cnt_nxt == C_LAST_BIT);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            sdo         <= 1'b0;
            sdo_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            sdo         <= w_sdo_nxt;
            sdo_valid   <= w_sdo_valid_nxt;
            frame_start <= w_frame_start_nxt;
            frame_end   <= w_frame_end_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
//  Module      : tb_bit_serializer
//  Description : Self-checking bench for bit_serializer in three configurations
//                (default, MSB-first, back-to-back) against a frame-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bit_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] r_data [3];
    logic [2:0]   r_valid;
    logic [2:0]   w_ready, w_sdo, w_sv, w_fs, w_fe, w_busy;
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .GAP_CYCLES(1), .LSB_FIRST(1)) u_def (
        .clk(clk), .rst_n(rst_n), .in_data(r_data[0]), .in_valid(r_valid[0]),
        .in_ready(w_ready[0]), .sdo(w_sdo[0]), .sdo_valid(w_sv[0]),
        .frame_start(w_fs[0]), .frame_end(w_fe[0]), .busy(w_busy[0]));

    bit_serializer #(.WIDTH(W), .GAP_CYCLES(1), .LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(r_data[1]), .in_valid(r_valid[1]),
        .in_ready(w_ready[1]), .sdo(w_sdo[1]), .sdo_valid(w_sv[1]),
        .frame_start(w_fs[1]), .frame_end(w_fe[1]), .busy(w_busy[1]));

    bit_serializer #(.WIDTH(W), .GAP_CYCLES(0), .LSB_FIRST(1)) u_b2b (
        .clk(clk), .rst_n(rst_n), .in_data(r_data[2]), .in_valid(r_valid[2]),
        .in_ready(w_ready[2]), .sdo(w_sdo[2]), .sdo_valid(w_sv[2]),
        .frame_start(w_fs[2]), .frame_end(w_fe[2]), .busy(w_busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit i of the serial frame for word w: data bits in the chosen order, then parity.
    function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit lsb);
        if (i >= W) return ^w;
        return lsb ? w[i] : w[W-1-i];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated frame on DUT d (gap of one cycle); optional in_valid pulse mid-frame.
    task automatic run_frame(input int d, input logic [W-1:0] w, input bit lsb, input int pulse);
        r_data[d]  = w;
        r_valid[d] = 1'b1;
        check($sformatf("d%0d_idle_ready", d), 32'(w_ready[d]), 32'd1);
        step();
        r_valid[d] = 1'b0;
        r_data[d]  = W'($urandom);
        for (int c = 1; c <= FL; c++) begin
            check($sformatf("d%0d_w%0h_c%0d_sdo", d, w, c), 32'(w_sdo[d]), 32'(exp_bit(w, c - 1, lsb)));
            check($sformatf("d%0d_c%0d_valid", d, c), 32'(w_sv[d]), 32'd1);
            check($sformatf("d%0d_c%0d_start", d, c), 32'(w_fs[d]), 32'(c == 1));
            check($sformatf("d%0d_c%0d_end", d, c), 32'(w_fe[d]), 32'(c == FL));
            check($sformatf("d%0d_c%0d_ready", d, c), 32'(w_ready[d]), 32'd0);
            check($sformatf("d%0d_c%0d_busy", d, c), 32'(w_busy[d]), 32'd1);
            if (c == pulse) begin
                r_valid[d] = 1'b1;
                r_data[d]  = '1;
            end else begin
                r_valid[d] = 1'b0;
            end
            step();
        end
        check($sformatf("d%0d_gap_valid", d), 32'(w_sv[d]), 32'd0);
        check($sformatf("d%0d_gap_sdo", d), 32'(w_sdo[d]), 32'd0);
        check($sformatf("d%0d_gap_ready", d), 32'(w_ready[d]), 32'd0);
        check($sformatf("d%0d_gap_busy", d), 32'(w_busy[d]), 32'd1);
        step();
        check($sformatf("d%0d_after_ready", d), 32'(w_ready[d]), 32'd1);
        check($sformatf("d%0d_after_busy", d), 32'(w_busy[d]), 32'd0);
        check($sformatf("d%0d_after_valid", d), 32'(w_sv[d]), 32'd0);
    endtask

    // Contiguous stream of n words on the zero-gap DUT, in_valid held between words.
    task automatic run_b2b(input logic [W-1:0] ws [4], input int n);
        r_data[2]  = ws[0];
        r_valid[2] = 1'b1;
        step();
        for (int c = 1; c <= n * FL; c++) begin
            int k, i;
            k = (c - 1) / FL;
            i = (c - 1) % FL;
            if (i == 0) begin
                if (k + 1 < n) r_data[2] = ws[k + 1];
                r_valid[2] = (k + 1 < n);
            end
            check($sformatf("b2b_c%0d_sdo", c), 32'(w_sdo[2]), 32'(exp_bit(ws[k], i, 1'b1)));
            check($sformatf("b2b_c%0d_valid", c), 32'(w_sv[2]), 32'd1);
            check($sformatf("b2b_c%0d_start", c), 32'(w_fs[2]), 32'(i == 0));
            check($sformatf("b2b_c%0d_end", c), 32'(w_fe[2]), 32'(i == FL - 1));
            check($sformatf("b2b_c%0d_ready", c), 32'(w_ready[2]), 32'(i == FL - 1));
            check($sformatf("b2b_c%0d_busy", c), 32'(w_busy[2]), 32'd1);
            step();
        end
        check("b2b_end_valid", 32'(w_sv[2]), 32'd0);
        check("b2b_end_sdo", 32'(w_sdo[2]), 32'd0);
        check("b2b_end_ready", 32'(w_ready[2]), 32'd1);
        check("b2b_end_busy", 32'(w_busy[2]), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ws [4];
        rst_n   = 1'b0;
        r_valid = '0;
        for (int d = 0; d < 3; d++) r_data[d] = '0;
        step();
        step();
        #2 rst_n = 1'b1;
        step();

        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_d%0d_sdo", d), 32'(w_sdo[d]), 32'd0);
            check($sformatf("rst_d%0d_valid", d), 32'(w_sv[d]), 32'd0);
            check($sformatf("rst_d%0d_start", d), 32'(w_fs[d]), 32'd0);
            check($sformatf("rst_d%0d_end", d), 32'(w_fe[d]), 32'd0);
            check($sformatf("rst_d%0d_busy", d), 32'(w_busy[d]), 32'd0);
            check($sformatf("rst_d%0d_ready", d), 32'(w_ready[d]), 32'd1);
        end

        run_frame(0, 8'hA5, 1'b1, 0);
        run_frame(1, 8'h01, 1'b0, 0);
        ws = '{8'h0F, 8'hF0, 8'h00, 8'h00};
        run_b2b(ws, 2);
        run_frame(0, 8'h07, 1'b1, 0);
        run_frame(0, 8'h03, 1'b1, 0);
        run_frame(0, 8'h00, 1'b1, 4);

        // Abort a frame after three bits with an asynchronous reset.
        r_data[0]  = 8'hA5;
        r_valid[0] = 1'b1;
        step();
        r_valid[0] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("abort_c%0d_sdo", c), 32'(w_sdo[0]), 32'(exp_bit(8'hA5, c - 1, 1'b1)));
            if (c < 3) step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_sdo", 32'(w_sdo[0]), 32'd0);
        check("abort_valid", 32'(w_sv[0]), 32'd0);
        check("abort_start", 32'(w_fs[0]), 32'd0);
        check("abort_end", 32'(w_fe[0]), 32'd0);
        check("abort_busy", 32'(w_busy[0]), 32'd0);
        step();
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post_rst_c%0d_ready", c), 32'(w_ready[0]), 32'd1);
            check($sformatf("post_rst_c%0d_end", c), 32'(w_fe[0]), 32'd0);
            check($sformatf("post_rst_c%0d_valid", c), 32'(w_sv[0]), 32'd0);
        end
        run_frame(0, 8'h55, 1'b1, 0);

        for (int r = 0; r < 6; r++) begin
            run_frame(0, W'($urandom), 1'b1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, FL - 1)) : 0);
            run_frame(1, W'($urandom), 1'b0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, FL - 1)) : 0);
            for (int j = 0; j < 4; j++) ws[j] = W'($urandom);
            run_b2b(ws, int'($urandom_range(1, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
